// File: rtl/weight_buf_pkg.sv
// weight_buf_pkg: shared sizing, types and address helpers for the banked
// weight buffer (weight_bank_responder and its weight_bank_sram banks).
package weight_buf_pkg;

    localparam int NUM_LANES = 16;
    localparam int ADDR_W    = 17;
    localparam int DATA_W    = 8;
    localparam int BANK_BITS = 4;
    localparam int NUM_BANKS = 1 << BANK_BITS;
    localparam int DEPTH     = 9408;
    localparam int ROWS      = (DEPTH + NUM_BANKS - 1) / NUM_BANKS;
    localparam int ROW_W     = $clog2(ROWS);
    localparam int LANE_W    = $clog2(NUM_LANES);

    typedef logic [ADDR_W-1:0]    addr_t;
    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [ROW_W-1:0]     row_t;
    typedef logic [BANK_BITS-1:0] bank_t;
    typedef logic [LANE_W-1:0]    lane_t;

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        COLLECT,
        RESP
    } state_t;

    // Low address bits select the bank so consecutive bytes spread across banks.
    function automatic bank_t bank_of(input addr_t a);
        return a[BANK_BITS-1:0];
    endfunction

    // Remaining bits select the row; anything above the row width is dropped.
    function automatic row_t row_of(input addr_t a);
        return row_t'(a >> BANK_BITS);
    endfunction

    function automatic logic in_range(input addr_t a);
        return a < addr_t'(DEPTH);
    endfunction

endpackage

// File: rtl/weight_bank_sram.sv
// weight_bank_sram: one weight bank, single synchronous read port plus one
// write port. Reads and writes never target the same cycle in this design.
module weight_bank_sram
    import weight_buf_pkg::*;
(
    input  logic  clk,
    input  logic  rd_en,
    input  row_t  rd_row,
    output data_t rd_data,
    input  logic  wr_en,
    input  row_t  wr_row,
    input  data_t wr_data
);

    // NOTE: the storage array carries no reset so it maps onto a RAM macro;
    // weights are always loaded through the write port before use.
    data_t mem [ROWS];

    // Registered read and write of the bank storage.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_row] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_row];
        end
    end

endmodule

// File: rtl/weight_bank_responder.sv
// weight_bank_responder: banked weight buffer answering 16-lane read vectors.
// Bank conflicts are serialised (lowest lane first per bank); the full vector
// is returned at once. Optional macro WEIGHT_ADDR_RANGE_CHECK_EN adds the
// io_respErr port, suppresses reads for out-of-range lanes and drops
// out-of-range writes.
module weight_bank_responder
    import weight_buf_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        io_enable,
    input  logic                        io_reqValid,
    output logic                        io_reqReady,
    input  logic [NUM_LANES*ADDR_W-1:0] io_rdAddr,
    input  logic [NUM_LANES-1:0]        io_addrValid,
    output logic                        io_respValid,
    input  logic                        io_respReady,
    output logic [NUM_LANES*DATA_W-1:0] io_respData,
    input  logic                        io_wrEn,
    output logic                        io_wrReady,
    input  logic [ADDR_W-1:0]           io_wrAddr,
    input  logic [DATA_W-1:0]           io_wrData
`ifdef WEIGHT_ADDR_RANGE_CHECK_EN
    ,
    output logic [NUM_LANES-1:0]        io_respErr
`endif
);

    state_t               state;
    state_t               state_next;
    addr_t                addr_q     [NUM_LANES];
    data_t                collect_q  [NUM_LANES];
    logic [NUM_LANES-1:0] pending;
    logic [NUM_LANES-1:0] issue_mask;
    logic [NUM_LANES-1:0] lane_ok;
    logic [NUM_BANKS-1:0] pick_valid;
    logic [NUM_BANKS-1:0] rd_en;
    logic [NUM_BANKS-1:0] issued_q;
    logic [NUM_BANKS-1:0] bank_we;
    lane_t                pick_lane  [NUM_BANKS];
    lane_t                sel_q      [NUM_BANKS];
    row_t                 rd_row     [NUM_BANKS];
    data_t                rd_data    [NUM_BANKS];
    logic                 req_fire;
    logic                 wr_fire;

    // Lanes that will actually be read once the request is accepted.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
`ifdef WEIGHT_ADDR_RANGE_CHECK_EN
            lane_ok[i] = io_addrValid[i] && in_range(io_rdAddr[i*ADDR_W +: ADDR_W]);
`else
            lane_ok[i] = io_addrValid[i];
`endif
        end
    end

    assign req_fire = io_reqValid && io_reqReady;
`ifdef WEIGHT_ADDR_RANGE_CHECK_EN
    assign wr_fire  = io_wrEn && io_wrReady && in_range(io_wrAddr);
`else
    assign wr_fire  = io_wrEn && io_wrReady;
`endif

    // Per-bank priority pick: the lowest-numbered pending lane wins its bank.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        pick_valid = '0;
        issue_mask = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            pick_lane[b] = '0;
        end
        // Descending scan so the lowest lane overwrites any higher one.
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pick_valid[bank_of(addr_q[i])] = 1'b1;
                pick_lane[bank_of(addr_q[i])]  = lane_t'(i);
            end
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            rd_row[b] = row_of(addr_q[pick_lane[b]]);
            if (pick_valid[b]) begin
                issue_mask[pick_lane[b]] = 1'b1;
            end
        end
    end

    assign rd_en = pick_valid & {NUM_BANKS{state == SERVE}};

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign bank_we[b] = wr_fire && (bank_of(io_wrAddr) == bank_t'(b));

        weight_bank_sram u_sram (
            .clk     (clock),
            .rd_en   (rd_en[b]),
            .rd_row  (rd_row[b]),
            .rd_data (rd_data[b]),
            .wr_en   (bank_we[b]),
            .wr_row  (row_of(io_wrAddr)),
            .wr_data (io_wrData)
        );
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; reset forces all handshakes low.
    always_comb begin
        state_next   = state;
        io_reqReady  = 1'b0;
        io_wrReady   = 1'b0;
        io_respValid = 1'b0;
        unique case (state)
            IDLE: begin
                io_wrReady  = 1'b1;
                io_reqReady = io_enable;
                if (io_reqValid && io_enable) begin
                    state_next = (lane_ok != '0) ? SERVE : COLLECT;
                end
            end
            SERVE: begin
                if ((pending & ~issue_mask) == '0) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                state_next = RESP;
            end
            RESP: begin
                io_respValid = 1'b1;
                if (io_respReady) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (reset) begin
            io_reqReady  = 1'b0;
            io_wrReady   = 1'b0;
            io_respValid = 1'b0;
        end
    end

    // Pending mask, issue tracking and per-lane collect registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending  <= '0;
            issued_q <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                collect_q[i] <= '0;
            end
        end else begin
            issued_q <= rd_en;
            if (req_fire) begin
                pending <= lane_ok;
                for (int i = 0; i < NUM_LANES; i++) begin
                    collect_q[i] <= '0;
                end
            end else begin
                pending <= pending & ~issue_mask;
                // Read data lands one cycle after issue; route it by the
                // lane each bank picked in the previous cycle.
                for (int b = 0; b < NUM_BANKS; b++) begin
                    if (issued_q[b]) begin
                        collect_q[sel_q[b]] <= rd_data[b];
                    end
                end
            end
        end
    end

    // Request addresses and registered lane-select need no reset.
    always_ff @(posedge clock) begin
        sel_q <= pick_lane;
        if (req_fire) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                addr_q[i] <= io_rdAddr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Pack the collect registers onto the response bus.
    always_comb begin
        io_respData = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            io_respData[i*DATA_W +: DATA_W] = collect_q[i];
        end
    end

`ifdef WEIGHT_ADDR_RANGE_CHECK_EN
    logic [NUM_LANES-1:0] err_q;

    // Out-of-range flags captured at accept, shown only with the response.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= '0;
        end else if (req_fire) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                err_q[i] <= io_addrValid[i] && !in_range(io_rdAddr[i*ADDR_W +: ADDR_W]);
            end
        end
    end

    assign io_respErr = err_q & {NUM_LANES{io_respValid}};
`endif

endmodule

// File: tb/tb_weight_bank_responder.sv
// tb_weight_bank_responder: randomized self-checking bench for
// weight_bank_responder against a byte-array reference model.
// Honours WEIGHT_ADDR_RANGE_CHECK_EN when the design is built with it.
module tb_weight_bank_responder;
    import weight_buf_pkg::*;

    logic                        clock = 1'b0;
    logic                        reset = 1'b1;
    logic                        io_enable = 1'b0;
    logic                        io_reqValid = 1'b0;
    logic                        io_reqReady;
    logic [NUM_LANES*ADDR_W-1:0] io_rdAddr = '0;
    logic [NUM_LANES-1:0]        io_addrValid = '0;
    logic                        io_respValid;
    logic                        io_respReady = 1'b0;
    logic [NUM_LANES*DATA_W-1:0] io_respData;
    logic                        io_wrEn = 1'b0;
    logic                        io_wrReady;
    logic [ADDR_W-1:0]           io_wrAddr = '0;
    logic [DATA_W-1:0]           io_wrData = '0;
`ifdef WEIGHT_ADDR_RANGE_CHECK_EN
    logic [NUM_LANES-1:0]        io_respErr;
`endif

    weight_bank_responder dut (
        .clock        (clock),
        .reset        (reset),
        .io_enable    (io_enable),
        .io_reqValid  (io_reqValid),
        .io_reqReady  (io_reqReady),
        .io_rdAddr    (io_rdAddr),
        .io_addrValid (io_addrValid),
        .io_respValid (io_respValid),
        .io_respReady (io_respReady),
        .io_respData  (io_respData),
        .io_wrEn      (io_wrEn),
        .io_wrReady   (io_wrReady),
        .io_wrAddr    (io_wrAddr),
        .io_wrData    (io_wrData)
`ifdef WEIGHT_ADDR_RANGE_CHECK_EN
        ,
        .io_respErr   (io_respErr)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain byte array plus the current request.
    logic [DATA_W-1:0]    mem_model [DEPTH];
    logic [ADDR_W-1:0]    req_addr  [NUM_LANES];
    logic [NUM_LANES-1:0] req_mask;

    function automatic bit model_in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    function automatic bit lane_active(input int i);
`ifdef WEIGHT_ADDR_RANGE_CHECK_EN
        return req_mask[i] && model_in_range(req_addr[i]);
`else
        return req_mask[i];
`endif
    endfunction

    // Latency = (largest number of active lanes sharing a bank) + 2.
    function automatic int model_latency();
        int cnt [NUM_BANKS];
        int k;
        k = 0;
        for (int b = 0; b < NUM_BANKS; b++) cnt[b] = 0;
        for (int i = 0; i < NUM_LANES; i++)
            if (lane_active(i)) cnt[int'(req_addr[i]) % NUM_BANKS]++;
        for (int b = 0; b < NUM_BANKS; b++)
            if (cnt[b] > k) k = cnt[b];
        return k + 2;
    endfunction

    function automatic logic [NUM_LANES*DATA_W-1:0] model_data();
        logic [NUM_LANES*DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < NUM_LANES; i++)
            if (lane_active(i)) d[i*DATA_W +: DATA_W] = mem_model[int'(req_addr[i])];
        return d;
    endfunction

    function automatic logic [NUM_LANES-1:0] model_err();
        logic [NUM_LANES-1:0] e;
        e = '0;
`ifdef WEIGHT_ADDR_RANGE_CHECK_EN
        for (int i = 0; i < NUM_LANES; i++)
            e[i] = req_mask[i] && !model_in_range(req_addr[i]);
`endif
        return e;
    endfunction

    function automatic logic [NUM_LANES-1:0] dut_err();
`ifdef WEIGHT_ADDR_RANGE_CHECK_EN
        return io_respErr;
`else
        return '0;
`endif
    endfunction

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clock);
        io_wrEn   = 1'b1;
        io_wrAddr = a;
        io_wrData = d;
        @(posedge clock);
        #1;
        io_wrEn = 1'b0;
        if (model_in_range(a)) mem_model[int'(a)] = d;
    endtask

    // Drives req_addr/req_mask, optionally with a same-cycle write, and waits
    // (bounded) for the response. Returns observations only; callers compare.
    task automatic drive_request(input bit with_wr, input logic [ADDR_W-1:0] wa,
                                 input logic [DATA_W-1:0] wd, output bit ready_seen,
                                 output int lat, output logic [NUM_LANES*DATA_W-1:0] data,
                                 output logic [NUM_LANES-1:0] err);
        @(negedge clock);
        for (int i = 0; i < NUM_LANES; i++) io_rdAddr[i*ADDR_W +: ADDR_W] = req_addr[i];
        io_addrValid = req_mask;
        io_reqValid  = 1'b1;
        if (with_wr) begin
            io_wrEn   = 1'b1;
            io_wrAddr = wa;
            io_wrData = wd;
        end
        #1;
        ready_seen = io_reqReady;
        @(posedge clock);
        #1;
        io_reqValid = 1'b0;
        io_wrEn     = 1'b0;
        lat = 1;
        while (io_respValid !== 1'b1 && lat < 64) begin
            @(posedge clock);
            #1;
            lat++;
        end
        data = io_respData;
        err  = dut_err();
    endtask

    task automatic finish_response();
        @(negedge clock);
        io_respReady = 1'b1;
        @(posedge clock);
        #1;
        io_respReady = 1'b0;
    endtask

    // Runs one transaction from req_addr/req_mask and checks it fully.
    task automatic run_and_check(input string name, input int hold);
        bit ready_seen;
        int lat;
        logic [NUM_LANES*DATA_W-1:0] data;
        logic [NUM_LANES-1:0] err;
        int exp_lat;
        logic [NUM_LANES*DATA_W-1:0] exp_data;
        exp_lat  = model_latency();
        exp_data = model_data();
        drive_request(1'b0, '0, '0, ready_seen, lat, data, err);
        n_cmp++;
        if (ready_seen !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready: got %b expected 1", name, ready_seen);
        end
        n_cmp++;
        if (lat !== exp_lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (data !== exp_data) begin
            n_bad++;
            $display("FAIL %s data: got %h expected %h", name, data, exp_data);
        end
        n_cmp++;
        if (err !== model_err()) begin
            n_bad++;
            $display("FAIL %s err: got %h expected %h", name, err, model_err());
        end
        repeat (hold) begin
            @(posedge clock);
            #1;
            n_cmp++;
            if (io_respValid !== 1'b1 || io_respData !== exp_data) begin
                n_bad++;
                $display("FAIL %s hold: got valid %b data %h expected 1 %h",
                         name, io_respValid, io_respData, exp_data);
            end
        end
        finish_response();
        n_cmp++;
        if (io_respValid !== 1'b0 || io_reqReady !== 1'b1) begin
            n_bad++;
            $display("FAIL %s release: got valid %b ready %b expected 0 1",
                     name, io_respValid, io_reqReady);
        end
    endtask

    task automatic test_reset();
        io_enable = 1'b1;
        reset     = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++;
        if ({io_reqReady, io_wrReady, io_respValid} !== 3'b000 || io_respData !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rr %b wr %b rv %b data %h expected all 0",
                     io_reqReady, io_wrReady, io_respValid, io_respData);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (io_reqReady !== 1'b1 || io_wrReady !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_idle: got rr %b wr %b expected 1 1", io_reqReady, io_wrReady);
        end
    endtask

    task automatic preload();
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clock);
            io_wrEn   = 1'b1;
            io_wrAddr = ADDR_W'(a);
            io_wrData = DATA_W'(a);
            mem_model[a] = DATA_W'(a);
        end
        @(negedge clock);
        io_wrEn = 1'b0;
    endtask

    task automatic test_conflict_free();
        logic [NUM_LANES*DATA_W-1:0] spec_data;
        for (int i = 0; i < NUM_LANES; i++) begin
            req_addr[i] = ADDR_W'(i);
            spec_data[i*DATA_W +: DATA_W] = DATA_W'(i);
        end
        req_mask = '1;
        n_cmp++;
        if (model_latency() != 3 || model_data() !== spec_data) begin
            n_bad++;
            $display("FAIL conflict_free_model: got %0d expected 3", model_latency());
        end
        run_and_check("conflict_free", 0);
    endtask

    task automatic test_all_bank0();
        for (int i = 0; i < NUM_LANES; i++) req_addr[i] = ADDR_W'(16 * i);
        req_mask = '1;
        run_and_check("all_bank0", 0);
    endtask

    task automatic test_empty_mask();
        for (int i = 0; i < NUM_LANES; i++) req_addr[i] = ADDR_W'($urandom_range(0, DEPTH - 1));
        req_mask = '0;
        run_and_check("empty_mask", 0);
    endtask

    task automatic test_hold();
        for (int i = 0; i < NUM_LANES; i++) req_addr[i] = ADDR_W'($urandom_range(0, DEPTH - 1));
        req_mask = 16'h00F0;
        run_and_check("hold_pre", 0);
        run_and_check("hold", 5);
        @(negedge clock);
        #1;
        n_cmp++;
        if (io_reqReady !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_ready_during: got %b expected 1 in idle", io_reqReady);
        end
    endtask

    task automatic test_hold_ready_low();
        for (int i = 0; i < NUM_LANES; i++) req_addr[i] = ADDR_W'($urandom_range(0, DEPTH - 1));
        req_mask = 16'h00F0;
        begin
            bit rs;
            int lat;
            logic [NUM_LANES*DATA_W-1:0] d;
            logic [NUM_LANES-1:0] e;
            drive_request(1'b0, '0, '0, rs, lat, d, e);
            repeat (5) begin
                @(posedge clock);
                #1;
                n_cmp++;
                if (io_reqReady !== 1'b0) begin
                    n_bad++;
                    $display("FAIL resp_reqready: got %b expected 0", io_reqReady);
                end
            end
            finish_response();
        end
    endtask

    task automatic test_write_collision();
        bit ready_seen;
        int lat;
        logic [NUM_LANES*DATA_W-1:0] data;
        logic [NUM_LANES-1:0] err;
        for (int i = 0; i < NUM_LANES; i++) req_addr[i] = ADDR_W'(200 + i);
        req_addr[3] = ADDR_W'(100);
        req_mask = '1;
        mem_model[100] = 8'hA5;
        drive_request(1'b1, ADDR_W'(100), 8'hA5, ready_seen, lat, data, err);
        n_cmp++;
        if (data[3*DATA_W +: DATA_W] !== 8'hA5) begin
            n_bad++;
            $display("FAIL wr_collision_lane3: got %h expected a5", data[3*DATA_W +: DATA_W]);
        end
        n_cmp++;
        if (data !== model_data() || lat != model_latency()) begin
            n_bad++;
            $display("FAIL wr_collision_all: got %h lat %0d expected %h lat %0d",
                     data, lat, model_data(), model_latency());
        end
        finish_response();
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int i = 0; i < NUM_LANES; i++) begin
                case (mode)
                    0: req_addr[i] = ADDR_W'($urandom_range(0, DEPTH - 1));
                    1: req_addr[i] = ADDR_W'($urandom_range(0, ROWS - 1) * 16 + $urandom_range(0, 2));
                    default: req_addr[i] = ADDR_W'(1000 + 16 * $urandom_range(0, 3) + $urandom_range(0, 1));
                endcase
            end
            req_mask = NUM_LANES'($urandom);
            if ($urandom_range(0, 1) == 1)
                do_write(ADDR_W'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom));
            if (mode == 2 && $urandom_range(0, 1) == 1)
                do_write(req_addr[0], DATA_W'($urandom));
            run_and_check($sformatf("random_%0d", t), $urandom_range(0, 3));
        end
    endtask

    task automatic test_enable_low();
        bit seen_resp;
        seen_resp = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            req_addr[i] = ADDR_W'(i);
            io_rdAddr[i*ADDR_W +: ADDR_W] = req_addr[i];
        end
        @(negedge clock);
        io_enable    = 1'b0;
        io_addrValid = '1;
        io_reqValid  = 1'b1;
        #1;
        n_cmp++;
        if (io_reqReady !== 1'b0 || io_wrReady !== 1'b1) begin
            n_bad++;
            $display("FAIL enable_low_ready: got rr %b wr %b expected 0 1", io_reqReady, io_wrReady);
        end
        repeat (6) begin
            @(posedge clock);
            #1;
            if (io_respValid === 1'b1) seen_resp = 1'b1;
        end
        n_cmp++;
        if (seen_resp !== 1'b0) begin
            n_bad++;
            $display("FAIL enable_low_noresp: got %b expected 0", seen_resp);
        end
        @(negedge clock);
        io_reqValid = 1'b0;
        io_enable   = 1'b1;
    endtask

    task automatic test_reset_serve();
        bit seen_resp;
        seen_resp = 1'b0;
        @(negedge clock);
        for (int i = 0; i < NUM_LANES; i++) io_rdAddr[i*ADDR_W +: ADDR_W] = ADDR_W'(16 * i + 1);
        io_addrValid = '1;
        io_reqValid  = 1'b1;
        @(posedge clock);
        #1;
        io_reqValid = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (io_respValid !== 1'b0 || io_reqReady !== io_enable || io_respData !== '0) begin
            n_bad++;
            $display("FAIL reset_serve: got rv %b rr %b data %h expected 0 %b 0",
                     io_respValid, io_reqReady, io_respData, io_enable);
        end
        repeat (25) begin
            @(posedge clock);
            #1;
            if (io_respValid === 1'b1) seen_resp = 1'b1;
        end
        n_cmp++;
        if (seen_resp !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_serve_partial: got %b expected 0", seen_resp);
        end
        for (int i = 0; i < NUM_LANES; i++) req_addr[i] = ADDR_W'($urandom_range(0, DEPTH - 1));
        req_mask = '1;
        run_and_check("after_reset", 1);
    endtask

`ifdef WEIGHT_ADDR_RANGE_CHECK_EN
    task automatic test_range();
        for (int i = 0; i < NUM_LANES; i++) req_addr[i] = ADDR_W'($urandom_range(0, DEPTH - 1));
        req_addr[0] = ADDR_W'(DEPTH);
        req_addr[5] = ADDR_W'(DEPTH + 37);
        req_mask = '1;
        n_cmp++;
        if (model_err() !== 16'h0021) begin
            n_bad++;
            $display("FAIL range_model: got %h expected 0021", model_err());
        end
        do_write(ADDR_W'(DEPTH + 3), 8'h5A);
        run_and_check("range", 1);
        @(negedge clock);
        n_cmp++;
        if (io_respErr !== '0) begin
            n_bad++;
            $display("FAIL range_err_idle: got %h expected 0", io_respErr);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < NUM_LANES; i++) req_addr[i] = '0;
        req_mask = '0;
        test_reset();
        preload();
        test_conflict_free();
        test_all_bank0();
        test_empty_mask();
        test_hold();
        test_hold_ready_low();
        test_write_collision();
        test_enable_low();
        test_random();
        test_reset_serve();
`ifdef WEIGHT_ADDR_RANGE_CHECK_EN
        test_range();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
